// File: rtl/muldiv_pkg.sv
// Shared definitions for the mult/div sequencer: ALU control codes, FSM and op encodings.
package muldiv_pkg;

    // Must stay aligned with the ALU control decoder.
    localparam logic [4:0] ALU_MULT  = 5'b01001;
    localparam logic [4:0] ALU_MULTU = 5'b01010;
    localparam logic [4:0] ALU_DIV   = 5'b00100;
    localparam logic [4:0] ALU_DIVU  = 5'b01011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX
    } state_t;

    typedef enum logic [1:0] {
        OP_MULT,
        OP_MULTU,
        OP_DIV,
        OP_DIVU
    } op_t;

    function automatic logic is_legal(input logic [4:0] ctrl);
        return (ctrl == ALU_MULT) || (ctrl == ALU_MULTU) ||
               (ctrl == ALU_DIV)  || (ctrl == ALU_DIVU);
    endfunction

    function automatic op_t decode_op(input logic [4:0] ctrl);
        case (ctrl)
            ALU_MULTU: return OP_MULTU;
            ALU_DIV:   return OP_DIV;
            ALU_DIVU:  return OP_DIVU;
            default:   return OP_MULT;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiply / restoring divide on the {upper,lower} accumulator.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opnd,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic                 o_qbit
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;

    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_trial = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opnd};
        o_qbit  = 1'b0;
        o_acc   = '0;
        if (i_is_div) begin
            // Quotient LSB slot is left clear; the caller merges o_qbit in.
            o_qbit = ~w_trial[WIDTH];
            o_acc  = {(o_qbit ? w_trial[WIDTH-1:0] : i_acc[2*WIDTH-2:WIDTH-1]),
                      i_acc[WIDTH-2:0], 1'b0};
        end else begin
            o_acc  = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MIPS mult/multu/div/divu sequencer owning the HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves ITER once the remaining multiplier bits are zero.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t               r_state;
    state_t               w_next;
    op_t                  r_op;
    logic [WIDTH-1:0]     r_a_raw;
    logic [WIDTH-1:0]     r_b_raw;
    logic [WIDTH-1:0]     r_opnd;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg_res;
    logic                 r_neg_rem;
    logic                 r_dbz_flag;
    logic                 r_done;
    logic                 r_div_by_zero;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]     r_mrem;
`endif

    logic                 w_busy;
    logic                 w_accept;
    logic                 w_is_div;
    logic                 w_signed;
    logic                 w_iter_last;
    logic                 w_commit;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [2*WIDTH-1:0]   w_step_acc;
    logic                 w_qbit;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    assign w_accept = start && is_legal(alu_ctrl) && !flush;
    assign w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign w_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
    assign w_abs_a  = (w_signed && r_a_raw[WIDTH-1]) ? -r_a_raw : r_a_raw;
    assign w_abs_b  = (w_signed && r_b_raw[WIDTH-1]) ? -r_b_raw : r_b_raw;
    assign w_commit = (r_state == ST_FIX) && !flush;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_iter_last = (r_cnt == CNT_W'(1)) || (!w_is_div && (r_mrem[WIDTH-1:1] == '0));
`else
    assign w_iter_last = (r_cnt == CNT_W'(1));
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (w_is_div),
        .i_acc    (r_acc),
        .i_opnd   (r_opnd),
        .o_acc    (w_step_acc),
        .o_qbit   (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_PREP;
            ST_PREP: w_next = ST_ITER;
            ST_ITER: if (w_iter_last) w_next = ST_FIX;
            ST_FIX:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (flush && (r_state != ST_IDLE)) begin
            w_next = ST_IDLE;
        end
    end

    always_comb begin
        w_busy = (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= OP_MULT;
            r_a_raw    <= '0;
            r_b_raw    <= '0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dbz_flag <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            r_mrem     <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op    <= decode_op(alu_ctrl);
                        r_a_raw <= op_a;
                        r_b_raw <= op_b;
                    end
                end
                ST_PREP: begin
                    r_neg_res  <= w_signed && (r_a_raw[WIDTH-1] ^ r_b_raw[WIDTH-1]);
                    r_neg_rem  <= w_signed && r_a_raw[WIDTH-1];
                    r_dbz_flag <= w_is_div && (r_b_raw == '0);
                    r_opnd     <= w_is_div ? w_abs_b : w_abs_a;
                    r_acc      <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                    r_cnt      <= CNT_W'(WIDTH);
`ifdef MULDIV_EARLY_OUT_EN
                    r_mrem     <= w_abs_b;
`endif
                end
                ST_ITER: begin
                    r_acc <= w_step_acc | {{(2*WIDTH-1){1'b0}}, w_qbit};
                    r_cnt <= r_cnt - CNT_W'(1);
`ifdef MULDIV_EARLY_OUT_EN
                    r_mrem <= r_mrem >> 1;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
        // An early exit leaves the product r_cnt bit positions high; realign it.
        w_prod = r_acc >> r_cnt;
`else
        w_prod = r_acc;
`endif
        w_res_hi = '0;
        w_res_lo = '0;
        if (w_is_div) begin
            if (r_dbz_flag) begin
                w_res_lo = '1;
                w_res_hi = r_a_raw;
            end else begin
                w_res_lo = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                w_res_hi = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            end
        end else begin
            {w_res_hi, w_res_lo} = r_neg_res ? -w_prod : w_prod;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
        end else begin
            r_done        <= w_commit;
            r_div_by_zero <= w_commit && r_dbz_flag;
            if (w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (!w_busy) begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
            end
        end
    end

    assign busy        = w_busy;
    assign done        = r_done;
    assign div_by_zero = r_div_by_zero;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: arithmetic reference model plus directed literal checks.
module tb_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [4:0] C_MULT  = 5'b01001;
    localparam logic [4:0] C_MULTU = 5'b01010;
    localparam logic [4:0] C_DIV   = 5'b00100;
    localparam logic [4:0] C_DIVU  = 5'b01011;
`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [4:0]    alu_ctrl = '0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          flush = 1'b0;
    logic          hi_we = 1'b0;
    logic          lo_we = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alu_ctrl    (alu_ctrl),
        .op_a        (op_a),
        .op_b        (op_b),
        .flush       (flush),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic         m_dbz = 1'b0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    logic         p_dbz = 1'b0;

    function automatic bit legal(input logic [4:0] c);
        return (c == C_MULT) || (c == C_MULTU) || (c == C_DIV) || (c == C_DIVU);
    endfunction

    function automatic void compute(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] rh, output logic [W-1:0] rl,
                                    output logic dz, output int lat);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        logic [W-1:0]    mag;
        int              bl;
        dz  = 1'b0;
        lat = W + 3;
        rh  = '0;
        rl  = '0;
        mag = b;
        sa  = a;
        sb  = b;
        if (c == C_MULT) begin
            sp = longint'(sa) * longint'(sb);
            {rh, rl} = sp;
            if (b[W-1]) mag = -b;
        end else if (c == C_MULTU) begin
            up = longint'({32'd0, a}) * longint'({32'd0, b});
            {rh, rl} = up;
        end else if (b == '0) begin
            dz = 1'b1;
            rl = '1;
            rh = a;
        end else if (c == C_DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                rl = a;
                rh = '0;
            end else begin
                rl = sa / sb;
                rh = sa % sb;
            end
        end else begin
            rl = a / b;
            rh = a % b;
        end
        if (EARLY && (c == C_MULT || c == C_MULTU)) begin
            bl = 0;
            for (int i = 0; i < W; i++) if (mag[i]) bl = i + 1;
            lat = 3 + ((bl < 1) ? 1 : bl);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int lat;
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_dbz  = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
        end else begin
            m_done = 1'b0;
            m_dbz  = 1'b0;
            if (m_left > 0) begin
                if (flush) begin
                    m_left = 0;
                end else if (m_left == 1) begin
                    m_hi   = p_hi;
                    m_lo   = p_lo;
                    m_done = 1'b1;
                    m_dbz  = p_dbz;
                    m_left = 0;
                end else begin
                    m_left--;
                end
            end else begin
                if (hi_we) m_hi = wdata;
                if (lo_we) m_lo = wdata;
                if (start && !flush && legal(alu_ctrl)) begin
                    compute(alu_ctrl, op_a, op_b, p_hi, p_lo, p_dbz, lat);
                    m_left = lat - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_left > 0);
            chk("done", done, m_done);
            chk("div_by_zero", div_by_zero, m_dbz);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    // ---------------- stimulus ----------------
    task automatic start_op(input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int cyc0, input int exp_cyc);
        int cyc;
        cyc = cyc0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_cycle"}, cyc, exp_cyc);
    endtask

    task automatic run(input string name, input logic [4:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input int ecyc, input logic edz);
        start_op(c, a, b);
        wait_done(name, 1, ecyc);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
        chk({name, "_dbz"}, div_by_zero, edz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_idle", hi, 32'h0000_1234);

        // reset in the middle of ITER
        start_op(C_MULT, 32'd100, 32'd3);
        repeat (8) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_done", done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run("mult7x6",     C_MULT,  32'd7,          32'd6,          32'h0,          32'd42,         EARLY ? 6 : 35, 1'b0);
        run("multm1x2",    C_MULT,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFE,  EARLY ? 5 : 35, 1'b0);
        run("multuff_x2",  C_MULTU, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001,  32'hFFFF_FFFE,  EARLY ? 5 : 35, 1'b0);
        run("multm3x5",    C_MULT,  32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1,  EARLY ? 6 : 35, 1'b0);
        run("divm7_2",     C_DIV,   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  35, 1'b0);
        run("div7_m2",     C_DIV,   32'd7,          32'hFFFF_FFFE,  32'h0000_0001,  32'hFFFF_FFFD,  35, 1'b0);
        run("divu7_2",     C_DIVU,  32'd7,          32'd2,          32'd1,          32'd3,          35, 1'b0);
        run("divuff_10",   C_DIVU,  32'hFFFF_FFFF,  32'd10,         32'd5,          32'h1999_9999,  35, 1'b0);
        run("divmin_m1",   C_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  35, 1'b0);
        run("divu5_0",     C_DIVU,  32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  35, 1'b1);
        run("divm5_0",     C_DIV,   32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  32'hFFFF_FFFF,  35, 1'b1);

        // flush at cycle 10 of a mult
        start_op(C_MULT, 32'd9, 32'd9);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        repeat (40) @(negedge clk);
        chk("flush_hi", hi, 32'hFFFF_FFFB);
        chk("flush_lo", lo, 32'hFFFF_FFFF);

        // flush in IDLE blocks start; illegal code ignored
        @(negedge clk);
        alu_ctrl = C_MULT;
        start = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("idle_flush_busy", busy, 1'b0);
        alu_ctrl = 5'b00000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("illegal_busy", busy, 1'b0);

        // start and mthi while busy are ignored; mthi in done cycle lands
        start_op(C_MULTU, 32'd10, 32'd20);
        repeat (5) @(negedge clk);
        alu_ctrl = C_DIVU;
        op_a = 32'd1;
        op_b = 32'd1;
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        wait_done("busy_ign", 7, EARLY ? 8 : 35);
        chk("busy_ign_hi", hi, 32'h0);
        chk("busy_ign_lo", lo, 32'd200);
        hi_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        hi_we = 1'b0;
        chk("done_mthi_hi", hi, 32'hCAFE_F00D);
        chk("done_mthi_lo", lo, 32'd200);
        lo_we = 1'b1;
        wdata = 32'h0000_0055;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_idle", lo, 32'h0000_0055);

        run("mult9x3",     C_MULT,  32'd9,          32'd3,          32'h0,          32'd27,         EARLY ? 5 : 35, 1'b0);
        run("mult9x0",     C_MULT,  32'd9,          32'd0,          32'h0,          32'h0,          EARLY ? 4 : 35, 1'b0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
